// File: rtl/vga_tile_engine.sv
// Tile-mapped VGA scan-out: timing counters, tile-map fetch, glyph fetch, colour key.
// Latency: a counter position reaches the pins 2 pixel ticks (4 clk) after it is issued.
// Backpressure: none; free-running raster, memories must answer 1 clk after each address.
module vga_tile_engine #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int TILE_LOG2        = 4,
  parameter int SYS_ADDR_WIDTH   = 16,
  parameter int SYS_DATA_WIDTH   = 16,
  parameter int MAP_BASE         = 0,
  parameter int GLYPH_ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SYS_DATA_WIDTH-1:0]   sys_data,
  input  logic [23:0]                 glyph_pixel,
  input  logic [23:0]                 bg_color,
  input  logic [9:0]                  scroll_x,
  input  logic [9:0]                  scroll_y,
  output logic [SYS_ADDR_WIDTH-1:0]   sys_addr,
  output logic [GLYPH_ADDR_WIDTH-1:0] glyph_addr,
  output logic                        vga_clk,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        vga_blank_n,
  output logic [7:0]                  r,
  output logic [7:0]                  g,
  output logic [7:0]                  b,
  output logic                        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GW      = 8 + 2 * TILE_LOG2;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [23:0]   KEY      = 24'hFF00FF;

  logic                      tick;
  logic [HW-1:0]             hcount;
  logic [VW-1:0]             vcount;
  logic [9:0]                sx_lat, sy_lat, sx_eff, sy_eff, ex, ey;
  logic [SYS_ADDR_WIDTH-1:0] addr_next;
  logic [TILE_LOG2-1:0]      row_q, col_q;
  logic                      addr_vld;
  logic                      hs_now, vs_now, active_now;
  logic                      hs_d1, vs_d1, blank_d1;
  logic [23:0]               pix_sel;
  logic [GW-1:0]             glyph_vec;
  logic                      unused_sys_hi;

  // Only the tile id byte of the map word carries meaning.
  assign unused_sys_hi = ^sys_data[SYS_DATA_WIDTH-1:8];

  // First tick of line 0; tick is low in reset so this is quiet there too.
  assign frame_start = tick && (hcount == '0) && (vcount == '0);

  // Address generation; the frame's first pixel already uses the freshly sampled scroll.
  always_comb begin
    sx_eff     = frame_start ? scroll_x : sx_lat;
    sy_eff     = frame_start ? scroll_y : sy_lat;
    ex         = 10'(hcount) + sx_eff;
    ey         = 10'(vcount) + sy_eff;
    addr_next  = SYS_ADDR_WIDTH'(MAP_BASE)
               + (SYS_ADDR_WIDTH'(ey >> TILE_LOG2) << (10 - TILE_LOG2))
               + SYS_ADDR_WIDTH'(ex >> TILE_LOG2);
    hs_now     = !((hcount >= HS_START) && (hcount < HS_END));
    vs_now     = !((vcount >= VS_START) && (vcount < VS_END));
    active_now = (hcount < H_ACT) && (vcount < V_ACT);
    glyph_vec  = {sys_data[7:0], row_q, col_q};
    pix_sel    = 24'h0;
    if (blank_d1) pix_sel = (glyph_pixel == KEY) ? bg_color : glyph_pixel;
  end

  // Pixel tick toggle; vga_clk rises on the cycle after each tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick    <= 1'b0;
      vga_clk <= 1'b0;
    end else begin
      tick    <= ~tick;
      vga_clk <= tick;
    end
  end

  // Raster counters, advanced once per pixel tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  // Scroll offsets are frozen for the whole frame at its start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx_lat <= '0;
      sy_lat <= '0;
    end else if (frame_start) begin
      sx_lat <= scroll_x;
      sy_lat <= scroll_y;
    end
  end

  // Stage 1: issue the tile-map address and launch the sync/blank delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sys_addr <= '0;
      row_q    <= '0;
      col_q    <= '0;
      addr_vld <= 1'b0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b0;
    end else if (tick) begin
      sys_addr <= addr_next;
      row_q    <= ey[TILE_LOG2-1:0];
      col_q    <= ex[TILE_LOG2-1:0];
      addr_vld <= 1'b1;
      hs_d1    <= hs_now;
      vs_d1    <= vs_now;
      blank_d1 <= active_now;
    end
  end

  // Stage 2: tile id returned by the map forms the glyph ROM address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glyph_addr <= '0;
    end else if (!tick && addr_vld) begin
      glyph_addr <= GLYPH_ADDR_WIDTH'(glyph_vec);
    end
  end

  // Stage 3: colour register plus matching sync/blank registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      {r, g, b}   <= 24'h0;
    end else if (tick) begin
      vga_hs      <= hs_d1;
      vga_vs      <= vs_d1;
      vga_blank_n <= blank_d1;
      {r, g, b}   <= pix_sel;
    end
  end

endmodule

// File: tb/tb_vga_tile_engine.sv
// Bench for vga_tile_engine with a reduced raster and a pixel-number reference model.
// Expected pins are derived from the edge count since reset release.
// Tile map and glyph ROM are modelled as 1-clk-latency lookups.
module tb_vga_tile_engine;
  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 3;
  localparam int TL = 4, AW = 12, DW = 16, GAW = 16, MB = 'hF80;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [56:0] RST = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 12'h0, 16'h0};

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [DW-1:0]  sys_data;
  logic [23:0]    glyph_pixel, bg_color;
  logic [9:0]     scroll_x, scroll_y;
  logic [AW-1:0]  sys_addr;
  logic [GAW-1:0] glyph_addr;
  logic           vga_clk, vga_hs, vga_vs, vga_blank_n, frame_start;
  logic [7:0]     r, g, b;

  logic [7:0]  tile_mem [256];
  logic [7:0]  hi_mem   [256];
  logic [23:0] pix_mem  [256];
  logic        force_key;

  int total = 0, bad = 0;
  int k, last_a, last_o;
  int fsx [64];
  int fsy [64];
  logic [AW-1:0]  e_addr;
  logic [GAW-1:0] e_glyph;
  logic [23:0]    e_rgb;
  logic           e_hs, e_vs, e_bl, e_vclk, e_fs;

  vga_tile_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .TILE_LOG2(TL), .SYS_ADDR_WIDTH(AW), .SYS_DATA_WIDTH(DW),
    .MAP_BASE(MB), .GLYPH_ADDR_WIDTH(GAW)
  ) dut (
    .clk(clk), .reset(reset), .sys_data(sys_data), .glyph_pixel(glyph_pixel),
    .bg_color(bg_color), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .sys_addr(sys_addr), .glyph_addr(glyph_addr), .vga_clk(vga_clk),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  // Memory models answering the DUT's current addresses.
  always_comb sys_data = {hi_mem[sys_addr[7:0]], tile_mem[sys_addr[7:0]]};
  always_comb glyph_pixel = force_key ? KEY : pix_mem[glyph_addr[7:0] ^ glyph_addr[15:8]];

  function automatic int ex_of(int n);
    return (n % HT + fsx[(n / FRAME) % 64]) % 1024;
  endfunction

  function automatic int ey_of(int n);
    return ((n / HT) % VT + fsy[(n / FRAME) % 64]) % 1024;
  endfunction

  function automatic logic [AW-1:0] addr_of(int n);
    int a;
    a = (MB + (ey_of(n) >> TL) * (1024 >> TL) + (ex_of(n) >> TL)) % (1 << AW);
    return a[AW-1:0];
  endfunction

  function automatic logic [GAW-1:0] glyph_of(int n);
    int w;
    w = int'(tile_mem[addr_of(n)[7:0]]) * (1 << (2 * TL))
      + (ey_of(n) % (1 << TL)) * (1 << TL) + ex_of(n) % (1 << TL);
    return w[GAW-1:0];
  endfunction

  function automatic logic [23:0] rom_of(logic [GAW-1:0] ga);
    if (force_key) return KEY;
    return pix_mem[ga[7:0] ^ ga[15:8]];
  endfunction

  function automatic logic [56:0] obs();
    return {vga_clk, frame_start, vga_hs, vga_vs, vga_blank_n, r, g, b, sys_addr, glyph_addr};
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, want);
    end
  endtask

  task automatic model_reset();
    k = 0; last_a = -1; last_o = -1;
    e_addr = '0; e_glyph = '0; e_rgb = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_vclk = 1'b0; e_fs = 1'b0;
  endtask

  // One clk: advance the model at the edge, compare every pin at the falling edge.
  task automatic step();
    int h, v;
    logic [23:0] pix;
    @(posedge clk);
    k++;
    if (k % 2 == 0) begin
      last_a = k / 2 - 1;
      if (last_a % FRAME == 0) begin
        fsx[(last_a / FRAME) % 64] = int'(scroll_x);
        fsy[(last_a / FRAME) % 64] = int'(scroll_y);
      end
      e_addr = addr_of(last_a);
      if (k >= 4) begin
        last_o = k / 2 - 2;
        h = last_o % HT;
        v = (last_o / HT) % VT;
        e_bl = (h < HA) && (v < VA);
        e_hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e_vs = !((v >= VA + VF) && (v < VA + VF + VS));
        pix = rom_of(glyph_of(last_o));
        e_rgb = !e_bl ? 24'h0 : ((pix == KEY) ? bg_color : pix);
      end
    end else if (k >= 3) begin
      e_glyph = glyph_of(k / 2 - 1);
    end
    e_vclk = (k % 2 == 0);
    e_fs = (k % 2 == 1) && (((k + 1) / 2 - 1) % FRAME == 0);
    @(negedge clk);
    check("pins", obs(), {e_vclk, e_fs, e_hs, e_vs, e_bl, e_rgb, e_addr, e_glyph});
  endtask

  // Step until the given pixel is issued (which=0) or shown on the pins (which=1).
  task automatic step_until(int which, int hh, int vv, string tag);
    int tgt, cur;
    logic found;
    tgt = vv * HT + hh;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8 && !found; i++) begin
      step();
      cur = (which == 0) ? last_a : last_o;
      if (k % 2 == 0 && cur >= 0 && cur % FRAME == tgt) found = 1'b1;
    end
    check({"reach_", tag}, 64'(found), 64'd1);
  endtask

  initial begin
    int hs_lo, vs_lo, fs_n, hs_fall;
    logic prev_hs;
    for (int i = 0; i < 256; i++) begin
      tile_mem[i] = 8'($urandom);
      hi_mem[i]   = 8'($urandom);
      pix_mem[i]  = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
    end
    tile_mem[1] = 8'h05;
    hi_mem[1]   = 8'h00;
    scroll_x = '0; scroll_y = '0; bg_color = 24'($urandom); force_key = 1'b0;
    model_reset();

    // Held in reset across several edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 64'(obs()), 64'(RST));

    // Release: frame_start during the first tick.
    reset = 1'b0;
    model_reset();
    step();
    check("fs_after_release", 64'(frame_start), 64'd1);

    // Pixel (17,33), no scroll: map entry 2*64+1 past MAP_BASE, wrapping at 4096.
    step_until(0, 17, 33, "p17_33");
    check("addr_17_33", 64'(sys_addr), 64'h001);
    step();
    check("glyph_17_33", 64'(glyph_addr), 64'h0511);

    // Mid-frame scroll change must not affect the current frame.
    scroll_x = 10'd8;
    step_until(0, 25, 34, "p25_34");
    check("addr_scroll_held", 64'(sys_addr), 64'h001);
    step_until(0, 0, 0, "next_frame");
    check("addr_scroll_col0", 64'(sys_addr), 64'hF80);
    step();
    check("glyph_scroll_col8", 64'(glyph_addr[7:0]), 64'h08);

    // Random scrolls and background colours.
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        scroll_x = 10'($urandom);
        scroll_y = 10'($urandom);
        bg_color = 24'($urandom);
      end
      step();
    end

    // Sync widths and frame period over exactly one frame of clocks.
    hs_lo = 0; vs_lo = 0; fs_n = 0; hs_fall = 0; prev_hs = vga_hs;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (!vga_hs) hs_lo++;
      if (!vga_vs) vs_lo++;
      if (frame_start) fs_n++;
      if (prev_hs && !vga_hs) hs_fall++;
      prev_hs = vga_hs;
    end
    check("hs_low_clks", 64'(hs_lo), 64'(VT * HS * 2));
    check("vs_low_clks", 64'(vs_lo), 64'(VS * HT * 2));
    check("frame_starts", 64'(fs_n), 64'd1);
    check("lines_per_frame", 64'(hs_fall), 64'(VT));

    // scroll_x = 1023 wraps ex to 0 at hcount 1.
    scroll_x = 10'd1023; scroll_y = 10'd0;
    step_until(0, 0, 0, "wrap_h0");
    check("addr_wrap_h0", 64'(sys_addr), 64'hFBF);
    step_until(0, 1, 0, "wrap_h1");
    check("addr_wrap_h1", 64'(sys_addr), 64'hF80);

    // Transparent key selects bg_color while active, black while blanked.
    force_key = 1'b1;
    bg_color = 24'h102030;
    step_until(1, 5, 5, "key_active");
    check("rgb_key_active", 64'({r, g, b}), 64'h102030);
    step_until(1, HA + 2, 5, "key_blank");
    check("rgb_key_blank", 64'({r, g, b}), 64'h0);
    check("blank_n_low", 64'(vga_blank_n), 64'd0);
    force_key = 1'b0;

    // Reset mid-frame acts without a clock edge, then restarts cleanly.
    scroll_x = 10'($urandom); scroll_y = 10'($urandom);
    step_until(0, 10, 20, "line20");
    reset = 1'b1;
    #1;
    check("reset_async", 64'(obs()), 64'(RST));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held_mid", 64'(obs()), 64'(RST));
    reset = 1'b0;
    model_reset();
    step();
    check("fs_after_rerelease", 64'(frame_start), 64'd1);
    step();
    check("fs_one_clk", 64'(frame_start), 64'd0);
    for (int i = 0; i < 600; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
